// File: rtl/note_recorder.sv
// Note recorder: captures keypad note/octave runs as {note, octave, ms-length} entries and replays them.
// Latency: outputs are registered, so playback of an entry starts the cycle after play_start or a pointer advance.
// Backpressure: none. Commands are single-cycle pulses; NOTE_RECORDER_LOOP_EN makes playback wrap until stop.
module note_recorder #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_1ms,
    input  logic                  rec_start,
    input  logic                  play_start,
    input  logic                  stop,
    input  logic [3:0]            in_note,
    input  logic [3:0]            in_octave,
    output logic [3:0]            out_note,
    output logic [3:0]            out_octave,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   entry_count,
    output logic                  full,
    output logic                  done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LAST_CNT = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, PLAY = 2'd2} state_t;

    typedef struct packed {
        logic [3:0]  note;
        logic [3:0]  octave;
        logic [15:0] len;
    } entry_t;

    state_t                state_q;
    logic [3:0]            out_note_q, out_oct_q;
    logic [3:0]            lat_note_q, lat_oct_q;
    logic [15:0]           len_q, rem_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  full_q, done_q;
    logic                  sync1_q, sync2_q, hist_q;

    entry_t                mem [DEPTH];

    logic                  tick, change, commit_vld, fill_last, last_ent;
    logic [DEPTH_LOG2-1:0] ptr_d;
    logic [DEPTH_LOG2:0]   count_d;
    entry_t                rd_first, rd_next, commit_dat;

    // Synchronizer flops come out of reset high so a clk_1ms already high is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= clk_1ms;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_comb begin
        tick       = sync2_q & ~hist_q;
        change     = {in_note, in_octave} != {lat_note_q, lat_oct_q};
        commit_vld = (state_q == REC) && (len_q != 16'd0) && (stop || change);
        fill_last  = commit_vld && (count_q == LAST_CNT);
        count_d    = count_q + 1'b1;
        ptr_d      = ptr_q + 1'b1;
        last_ent   = ({1'b0, ptr_q} == (count_q - 1'b1));
        rd_first   = mem[0];
        rd_next    = mem[ptr_d];
        commit_dat = {lat_note_q, lat_oct_q, len_q};
    end

    // Buffer is not cleared on reset; entry_count = 0 makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && commit_vld) begin
            mem[count_q[DEPTH_LOG2-1:0]] <= commit_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_note_q <= 4'd0;
            out_oct_q  <= 4'd0;
            lat_note_q <= 4'd0;
            lat_oct_q  <= 4'd0;
            len_q      <= 16'd0;
            rem_q      <= 16'd0;
            ptr_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    out_note_q <= 4'd0;
                    out_oct_q  <= 4'd0;
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (rec_start) begin
                        state_q    <= REC;
                        count_q    <= '0;
                        full_q     <= 1'b0;
                        lat_note_q <= in_note;
                        lat_oct_q  <= in_octave;
                        len_q      <= 16'd0;
                        out_note_q <= in_note;
                        out_oct_q  <= in_octave;
                    end else if (play_start && count_q != '0) begin
                        state_q    <= PLAY;
                        ptr_q      <= '0;
                        out_note_q <= rd_first.note;
                        out_oct_q  <= rd_first.octave;
                        rem_q      <= rd_first.len;
                    end
                end
                REC: begin
                    out_note_q <= in_note;
                    out_oct_q  <= in_octave;
                    if (commit_vld) begin
                        count_q <= count_d;
                    end
                    if (stop || fill_last) begin
                        state_q    <= IDLE;
                        full_q     <= fill_last;
                        out_note_q <= 4'd0;
                        out_oct_q  <= 4'd0;
                    end else if (change) begin
                        // A tick coinciding with a change belongs to the new entry.
                        lat_note_q <= in_note;
                        lat_oct_q  <= in_octave;
                        len_q      <= {15'd0, tick};
                    end else if (tick && len_q != 16'hFFFF) begin
                        len_q <= len_q + 16'd1;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state_q    <= IDLE;
                        out_note_q <= 4'd0;
                        out_oct_q  <= 4'd0;
                    end else if (tick) begin
                        if (rem_q == 16'd1) begin
                            if (last_ent) begin
                                done_q <= 1'b1;
`ifdef NOTE_RECORDER_LOOP_EN
                                ptr_q      <= '0;
                                out_note_q <= rd_first.note;
                                out_oct_q  <= rd_first.octave;
                                rem_q      <= rd_first.len;
`else
                                state_q    <= IDLE;
                                out_note_q <= 4'd0;
                                out_oct_q  <= 4'd0;
                                rem_q      <= 16'd0;
`endif
                            end else begin
                                ptr_q      <= ptr_d;
                                out_note_q <= rd_next.note;
                                out_oct_q  <= rd_next.octave;
                                rem_q      <= rd_next.len;
                            end
                        end else begin
                            rem_q <= rem_q - 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_note    = out_note_q;
    assign out_octave  = out_oct_q;
    assign state       = state_q;
    assign entry_count = count_q;
    assign full        = full_q;
    assign done        = done_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder (DEPTH_LOG2 = 2): table-driven recording segments, scoreboard-checked playback.
module tb_note_recorder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1ms = 1'b0;
    logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
    logic [3:0] in_note = 4'd0, in_octave = 4'd0;
    logic [3:0] out_note, out_octave;
    logic [1:0] state;
    logic [2:0] entry_count;
    logic       full, done;

    note_recorder #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .clk_1ms(clk_1ms),
        .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .in_note(in_note), .in_octave(in_octave),
        .out_note(out_note), .out_octave(out_octave),
        .state(state), .entry_count(entry_count), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    // One recording segment: key held for 'ticks' ms; end_tick means the change out of it lands on a tick.
    typedef struct {
        logic [3:0] note;
        logic [3:0] oct;
        int         ticks;
        bit         end_tick;
        int         exp_len;
    } seg_t;

    typedef struct {
        logic [3:0] note;
        logic [3:0] oct;
        int         len;
    } ent_t;

    seg_t tab [13];
    ent_t exp_q [$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ms_tick();
        clk_1ms = 1'b1;
        cyc(4);
        clk_1ms = 1'b0;
        cyc(4);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: rec_start = 1'b1;
            1: play_start = 1'b1;
            default: stop = 1'b1;
        endcase
        cyc(1);
        rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    endtask

    task automatic rec_group(input int lo, input int hi, input int exp_count, input int exp_full);
        in_note = tab[lo].note; in_octave = tab[lo].oct;
        cyc(1);
        pulse(0);
        check("rec_state", state, 1);
        for (int i = lo; i < hi; i++) begin
            if (i > lo) begin
                if (tab[i-1].end_tick) begin
                    // Rising clk_1ms reaches the tick pulse two edges later; change lands on that edge.
                    clk_1ms = 1'b1;
                    @(negedge clk);
                    @(negedge clk);
                    in_note = tab[i].note; in_octave = tab[i].oct;
                    cyc(1);
                    clk_1ms = 1'b0;
                    cyc(4);
                end else begin
                    in_note = tab[i].note; in_octave = tab[i].oct;
                    cyc(1);
                end
                if (tab[i].exp_len != 0) begin
                    check("monitor_note", out_note, tab[i].note);
                    check("monitor_oct", out_octave, tab[i].oct);
                end
            end
            repeat (tab[i].ticks) ms_tick();
            if (tab[i].exp_len != 0)
                exp_q.push_back('{tab[i].note, tab[i].oct, tab[i].exp_len});
        end
        pulse(2);
        cyc(1);
        check("rec_end_state", state, 0);
        check("rec_end_count", entry_count, exp_count);
        check("rec_end_full", full, exp_full);
        check("rec_end_out", out_note, 0);
    endtask

    task automatic play_check();
        ent_t e, first;
        int   n;
        n = exp_q.size();
        first = exp_q[0];
        done_cnt = 0;
        pulse(1);
        check("play_state", state, 2);
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            check("play_note", out_note, e.note);
            check("play_oct", out_octave, e.oct);
            repeat (e.len - 1) ms_tick();
            if (e.len > 1) check("play_hold", out_note, e.note);
            ms_tick();
            check("play_done_cnt", done_cnt, (k == n - 1) ? 1 : 0);
        end
`ifdef NOTE_RECORDER_LOOP_EN
        check("loop_state", state, 2);
        check("loop_wrap_note", out_note, first.note);
        check("loop_wrap_oct", out_octave, first.oct);
        pulse(2);
`endif
        check("play_end_state", state, 0);
        check("play_end_out", out_note, 0);
        check("play_end_oct", out_octave, 0);
    endtask

    initial begin
        tab[0]  = '{4'd3, 4'd2, 0, 1'b0, 0};
        tab[1]  = '{4'd1, 4'd4, 3, 1'b0, 3};
        tab[2]  = '{4'd5, 4'd4, 2, 1'b0, 2};
        tab[3]  = '{4'd2, 4'd3, 2, 1'b1, 2};
        tab[4]  = '{4'd7, 4'd3, 1, 1'b0, 2};
        tab[5]  = '{4'd9, 4'd5, 2, 1'b0, 2};
        tab[6]  = '{4'd6, 4'd2, 0, 1'b0, 0};
        tab[7]  = '{4'd9, 4'd6, 1, 1'b0, 1};
        tab[8]  = '{4'd1, 4'd1, 1, 1'b0, 1};
        tab[9]  = '{4'd2, 4'd1, 1, 1'b0, 1};
        tab[10] = '{4'd3, 4'd1, 1, 1'b0, 1};
        tab[11] = '{4'd4, 4'd1, 1, 1'b0, 1};
        tab[12] = '{4'd5, 4'd1, 1, 1'b0, 0};

        cyc(3);
        check("rst_state", state, 0);
        check("rst_out", out_note, 0);
        check("rst_count", entry_count, 0);
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        cyc(2);

        rec_group(0, 1, 0, 0);
        pulse(1);
        check("play_empty_state", state, 0);

        rec_start = 1'b1; stop = 1'b1;
        cyc(1);
        rec_start = 1'b0; stop = 1'b0;
        check("prio_stop", state, 0);
        rec_start = 1'b1; play_start = 1'b1;
        cyc(1);
        rec_start = 1'b0; play_start = 1'b0;
        check("prio_rec", state, 1);
        pulse(1);
        check("ignore_play_in_rec", state, 1);
        pulse(2);
        check("empty_rec_count", entry_count, 0);

        rec_group(1, 3, 2, 0);
        play_check();
        check("persist_count", entry_count, 2);

        rec_group(3, 5, 2, 0);
        play_check();

        rec_group(5, 8, 2, 0);
        play_check();

        done_cnt = 0;
        pulse(1);
        ms_tick();
        check("stop_play_hold", out_note, 9);
        pulse(2);
        check("stop_play_state", state, 0);
        check("stop_play_out", out_note, 0);
        check("stop_play_nodone", done_cnt, 0);

        rec_group(8, 13, 4, 1);
        play_check();

        pulse(1);
        cyc(2);
        check("midplay_state", state, 2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("midrst_state", state, 0);
        check("midrst_out", out_note, 0);
        check("midrst_count", entry_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
